// File: rtl/fifo8x9_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fifo8x9_ctrl_pkg
// Shared definitions for the 8x9 FIFO sequencing controller:
//   - default FIFO depth and occupancy-counter width
//   - controller state encoding (INIT / RUN / FLUSH)
// ---------------------------------------------------------------------------
package fifo8x9_ctrl_pkg;

    localparam int DEFAULT_DEPTH = 8;   // FIFO entries; pointers wrap after DEPTH-1
    localparam int DEFAULT_CW    = 4;   // occupancy counter width, holds 0..DEPTH

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,   // one cycle after reset, clears both FIFO pointers
        ST_RUN   = 2'd1,   // normal push/pop operation
        ST_FLUSH = 2'd2    // one cycle, empties the FIFO and clears error flags
    } state_t;

endpackage : fifo8x9_ctrl_pkg

// File: rtl/fifo_ring_idx.sv
// ---------------------------------------------------------------------------
// fifo_ring_idx
// Modulo-DEPTH index that shadows one of the FIFO's external pointers, plus
// the decode telling the controller the pointer sits on its last entry.
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset, index -> 0
//   clr     in   synchronous clear, index -> 0 (INIT / FLUSH)
//   adv     in   advance by one entry, wrapping DEPTH-1 -> 0
//   idx     out  current index
//   at_wrap out  index == DEPTH-1
// ---------------------------------------------------------------------------
module fifo_ring_idx
    import fifo8x9_ctrl_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [IW-1:0] idx,
    output logic          at_wrap
);

    logic [IW-1:0] r_idx;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_idx <= '0;
        end else if (adv) begin
            r_idx <= at_wrap ? '0 : r_idx + IW'(1);
        end
    end

    assign at_wrap = (r_idx == IW'(DEPTH - 1));
    assign idx     = r_idx;

endmodule : fifo_ring_idx

// File: rtl/fifo8x9_ctrl.sv
// ---------------------------------------------------------------------------
// fifo8x9_ctrl
// Sequencing controller for an 8-entry x 9-bit FIFO with external pointer
// controls. Converts push/pop requests into wren/WrInc/WrPtrClr and
// rden/RdInc/RdPtrClr, tracks occupancy, and keeps sticky error flags.
// Each pointer is cleared instead of incremented after its last entry, so
// the FIFO array is never addressed out of range.
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   push, pop, flush          requests (flush is a single-cycle pulse)
//   push_ok, pop_ok           request accepted this cycle (combinational)
//   rd_valid                  FIFO DataOut valid this cycle (registered)
//   full, empty, count        occupancy (registered)
//   overflow, underflow       sticky error flags
//   busy                      controller in INIT or FLUSH
//   wren, WrInc, WrPtrClr     FIFO write-side controls
//   rden, RdInc, RdPtrClr     FIFO read-side controls
// ---------------------------------------------------------------------------
module fifo8x9_ctrl
    import fifo8x9_ctrl_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CW    = DEFAULT_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    output logic          push_ok,
    output logic          pop_ok,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow,
    output logic          busy,
    output logic          wren,
    output logic          WrInc,
    output logic          WrPtrClr,
    output logic          rden,
    output logic          RdInc,
    output logic          RdPtrClr
);

    localparam int IW = $clog2(DEPTH);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_run;        // requests may be accepted this cycle
    logic          w_clr_ptrs;   // INIT or FLUSH: clear both pointers

    logic [CW-1:0] r_count;
    logic          r_rd_valid;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic          w_wr_wrap;
    logic          w_rd_wrap;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_rd_idx;
    logic          w_unused_idx;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next state / state decodes ----------------
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        w_clr_ptrs  = 1'b0;
        unique case (r_state)
            ST_INIT: begin
                w_clr_ptrs  = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // A flush cycle accepts nothing; the flush itself happens next cycle.
                w_run = !flush;
                if (flush) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_clr_ptrs  = 1'b1;
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // ---------------- acceptance ----------------
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop_ok  = w_run & pop & ~w_empty;
    // At full a push is still taken if a pop frees the slot in the same cycle.
    assign w_push_ok = w_run & push & (~w_full | w_pop_ok);

    // ---------------- occupancy, read valid, error flags ----------------
    always_ff @(posedge clk) begin
        if (rst || r_state == ST_FLUSH) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - CW'(1);
            end
            if (w_run && push && w_full && !w_pop_ok) begin
                r_overflow <= 1'b1;
            end
            // A pop at empty that coincides with an accepted push is paired
            // with that push rather than flagged as an error.
            if (w_run && pop && w_empty && !w_push_ok) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // rd_valid follows pop_ok by one cycle, matching the FIFO's registered DataOut.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop_ok;
        end
    end

    // ---------------- pointer shadows ----------------
    fifo_ring_idx #(.DEPTH(DEPTH)) u_wr_idx (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr_ptrs),
        .adv     (w_push_ok),
        .idx     (w_wr_idx),
        .at_wrap (w_wr_wrap)
    );

    fifo_ring_idx #(.DEPTH(DEPTH)) u_rd_idx (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr_ptrs),
        .adv     (w_pop_ok),
        .idx     (w_rd_idx),
        .at_wrap (w_rd_wrap)
    );

    // Index values are kept for debug visibility; only the wrap decodes drive logic.
    assign w_unused_idx = ^{w_wr_idx, w_rd_idx};

    // ---------------- outputs ----------------
    assign push_ok   = w_push_ok;
    assign pop_ok    = w_pop_ok;
    assign rd_valid  = r_rd_valid;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign busy      = w_clr_ptrs;

    // On the last entry the pointer is cleared instead of incremented.
    assign wren      = w_push_ok;
    assign WrInc     = w_push_ok & ~w_wr_wrap;
    assign WrPtrClr  = w_clr_ptrs | (w_push_ok & w_wr_wrap);
    assign rden      = w_pop_ok;
    assign RdInc     = w_pop_ok & ~w_rd_wrap;
    assign RdPtrClr  = w_clr_ptrs | (w_pop_ok & w_rd_wrap);

endmodule : fifo8x9_ctrl

// File: tb/tb_fifo8x9_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo8x9_ctrl
// Self-checking bench for fifo8x9_ctrl. A behavioural 8x9 FIFO with 8-bit
// external pointers is driven by the controller outputs; a queue-based
// reference model predicts every controller output and the data read back.
// ---------------------------------------------------------------------------
module tb_fifo8x9_ctrl;

    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk;
    logic          rst;
    logic          push;
    logic          pop;
    logic          flush;
    logic          push_ok;
    logic          pop_ok;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;
    logic          busy;
    logic          wren;
    logic          WrInc;
    logic          WrPtrClr;
    logic          rden;
    logic          RdInc;
    logic          RdPtrClr;

    fifo8x9_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_ok   (push_ok),
        .pop_ok    (pop_ok),
        .rd_valid  (rd_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .busy      (busy),
        .wren      (wren),
        .WrInc     (WrInc),
        .WrPtrClr  (WrPtrClr),
        .rden      (rden),
        .RdInc     (RdInc),
        .RdPtrClr  (RdPtrClr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural pointer-driven FIFO ----------------
    logic [8:0] din = '0;
    logic [8:0] f_mem [256];
    logic [7:0] f_wptr = 8'd3;   // arbitrary until INIT clears it
    logic [7:0] f_rptr = 8'd5;
    logic [8:0] f_dout = '0;

    always @(posedge clk) begin
        if (wren) f_mem[f_wptr] <= din;
        if (rden) f_dout <= f_mem[f_rptr];
        if (WrPtrClr) f_wptr <= 8'd0;
        else if (WrInc) f_wptr <= f_wptr + 8'd1;
        if (RdPtrClr) f_rptr <= 8'd0;
        else if (RdInc) f_rptr <= f_rptr + 8'd1;
    end

    // ---------------- reference model ----------------
    logic [8:0] m_q[$];
    bit         m_busy = 1'b1;
    bit         m_ovf, m_unf, m_rdv;
    logic [8:0] m_rdata;
    int         m_wr_n, m_rd_n;

    // expectations for the cycle currently being driven
    bit e_run, e_full, e_empty, e_push_ok, e_pop_ok;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs after the falling edge and check all outputs
    // against the model.
    task automatic drive(input bit r, input bit p, input bit q, input bit f, input logic [8:0] d);
        bit wr_last, rd_last;
        @(negedge clk);
        rst = r; push = p; pop = q; flush = f; din = d;
        #1;
        e_run     = !m_busy && !f;
        e_empty   = (m_q.size() == 0);
        e_full    = (m_q.size() == DEPTH);
        e_pop_ok  = e_run && q && !e_empty;
        e_push_ok = e_run && p && (!e_full || e_pop_ok);
        wr_last   = (m_wr_n % DEPTH) == DEPTH - 1;
        rd_last   = (m_rd_n % DEPTH) == DEPTH - 1;
        if (!r) begin
            check("push_ok",   push_ok,   e_push_ok);
            check("pop_ok",    pop_ok,    e_pop_ok);
            check("wren",      wren,      e_push_ok);
            check("rden",      rden,      e_pop_ok);
            check("WrInc",     WrInc,     e_push_ok && !wr_last);
            check("WrPtrClr",  WrPtrClr,  m_busy || (e_push_ok && wr_last));
            check("RdInc",     RdInc,     e_pop_ok && !rd_last);
            check("RdPtrClr",  RdPtrClr,  m_busy || (e_pop_ok && rd_last));
            check("count",     count,     m_q.size());
            check("full",      full,      e_full);
            check("empty",     empty,     e_empty);
            check("overflow",  overflow,  m_ovf);
            check("underflow", underflow, m_unf);
            check("busy",      busy,      m_busy);
            check("rd_valid",  rd_valid,  m_rdv);
            if (m_rdv) check("rd_data", f_dout, m_rdata);
            if (!m_busy) begin
                check("wr_ptr", f_wptr, m_wr_n % DEPTH);
                check("rd_ptr", f_rptr, m_rd_n % DEPTH);
            end
        end
    endtask

    // Advance the model across the rising edge.
    task automatic commit();
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_wr_n = 0; m_rd_n = 0;
            m_ovf  = 0; m_unf  = 0;
            m_rdv  = 0;
            m_busy = 1;
        end else begin
            m_rdv = e_pop_ok;
            if (e_pop_ok) begin
                m_rdata = m_q.pop_front();
                m_rd_n++;
            end
            if (e_push_ok) begin
                m_q.push_back(din);
                m_wr_n++;
            end
            if (e_run && push && e_full && !e_pop_ok) m_ovf = 1;
            if (e_run && pop && e_empty && !e_push_ok) m_unf = 1;
            if (m_busy) begin
                m_q.delete();
                m_wr_n = 0; m_rd_n = 0;
                m_ovf  = 0; m_unf  = 0;
            end
            m_busy = !m_busy && flush;
        end
    endtask

    task automatic cycle(input bit r, input bit p, input bit q, input bit f, input logic [8:0] d);
        drive(r, p, q, f, d);
        commit();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit push, pop, flush;
        bit push_ok, pop_ok;
        int count;
        bit full, empty, ovf, wrinc, wrclr, busy;
    } vec_t;

    function automatic vec_t mk(bit p, bit q, bit f, bit pk, bit qk, int c,
                                bit fu, bit em, bit ov, bit wi, bit wc, bit bz);
        vec_t v;
        v.push = p; v.pop = q; v.flush = f; v.push_ok = pk; v.pop_ok = qk; v.count = c;
        v.full = fu; v.empty = em; v.ovf = ov; v.wrinc = wi; v.wrclr = wc; v.busy = bz;
        return v;
    endfunction

    vec_t tbl[14];

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr_clr_at[$];
        int rd_clr_at[$];
        int rdv_seen;
        bit r, p, q, f;

        // idle after reset: INIT then RUN; eight pushes 0x100..0x107; overflow; swap at full
        tbl[0]  = mk(0,0,0, 0,0, 0, 0,1,0, 0,1, 1);
        tbl[1]  = mk(0,0,0, 0,0, 0, 0,1,0, 0,0, 0);
        for (int i = 0; i < 8; i++)
            tbl[2+i] = mk(1,0,0, 1,0, i, 0, (i == 0), 0, (i != 7), (i == 7), 0);
        tbl[10] = mk(1,0,0, 0,0, 8, 1,0,0, 0,0, 0);
        tbl[11] = mk(0,0,0, 0,0, 8, 1,0,1, 0,0, 0);
        tbl[12] = mk(1,1,0, 1,1, 8, 1,0,1, 1,0, 0);
        tbl[13] = mk(0,0,0, 0,0, 8, 1,0,1, 0,0, 0);

        rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0;
        cycle(1, 0, 0, 0, '0);
        cycle(1, 0, 0, 0, '0);

        for (int i = 0; i < 14; i++) begin
            drive(0, tbl[i].push, tbl[i].pop, tbl[i].flush, 9'h100 + 9'(i - 2));
            check($sformatf("tbl%0d.push_ok", i), push_ok,  tbl[i].push_ok);
            check($sformatf("tbl%0d.pop_ok", i),  pop_ok,   tbl[i].pop_ok);
            check($sformatf("tbl%0d.count", i),   count,    tbl[i].count);
            check($sformatf("tbl%0d.full", i),    full,     tbl[i].full);
            check($sformatf("tbl%0d.empty", i),   empty,    tbl[i].empty);
            check($sformatf("tbl%0d.ovf", i),     overflow, tbl[i].ovf);
            check($sformatf("tbl%0d.WrInc", i),   WrInc,    tbl[i].wrinc);
            check($sformatf("tbl%0d.WrPtrClr", i), WrPtrClr, tbl[i].wrclr);
            check($sformatf("tbl%0d.busy", i),    busy,     tbl[i].busy);
            commit();
        end

        // count 8 -> 5; the last pop's rd_valid lands in the flush cycle
        cycle(0, 0, 1, 0, '0);
        cycle(0, 0, 1, 0, '0);
        cycle(0, 0, 1, 0, '0);
        drive(0, 1, 0, 1, 9'h1AA);
        check("flush.count5", count, 5);
        check("flush.push_ok", push_ok, 0);
        check("flush.rd_valid_prev_pop", rd_valid, 1);
        commit();
        drive(0, 1, 0, 0, 9'h1AB);
        check("flush.busy", busy, 1);
        check("flush.WrPtrClr", WrPtrClr, 1);
        check("flush.RdPtrClr", RdPtrClr, 1);
        check("flush.push_ok_in_flush", push_ok, 0);
        commit();
        drive(0, 0, 0, 0, '0);
        check("after_flush.count", count, 0);
        check("after_flush.overflow", overflow, 0);
        check("after_flush.underflow", underflow, 0);
        commit();

        // push+pop at empty: only the push is taken, no underflow
        drive(0, 1, 1, 0, 9'h055);
        check("pp_empty.push_ok", push_ok, 1);
        check("pp_empty.pop_ok", pop_ok, 0);
        commit();
        drive(0, 0, 0, 0, '0);
        check("pp_empty.count", count, 1);
        check("pp_empty.underflow", underflow, 0);
        commit();
        cycle(0, 0, 1, 0, '0);
        cycle(0, 0, 1, 0, '0);
        drive(0, 0, 0, 0, '0);
        check("pop_empty.underflow", underflow, 1);
        commit();

        // wrap test: 20 words streamed through from cleared pointers
        cycle(0, 0, 0, 1, '0);
        cycle(0, 0, 0, 0, '0);
        rdv_seen = 0;
        for (int k = 0; k < 23; k++) begin
            drive(0, k < 20, k > 0 && k <= 20, 0, 9'h0A0 + 9'(k));
            if (wren && WrPtrClr) wr_clr_at.push_back(m_wr_n + 1);
            if (rden && RdPtrClr) rd_clr_at.push_back(m_rd_n + 1);
            if (rd_valid) rdv_seen++;
            commit();
        end
        check("wrap.wr_clr_pulses", wr_clr_at.size(), 2);
        check("wrap.rd_clr_pulses", rd_clr_at.size(), 2);
        if (wr_clr_at.size() == 2) begin
            check("wrap.wr_clr_first", wr_clr_at[0], 8);
            check("wrap.wr_clr_second", wr_clr_at[1], 16);
        end
        if (rd_clr_at.size() == 2) begin
            check("wrap.rd_clr_first", rd_clr_at[0], 8);
            check("wrap.rd_clr_second", rd_clr_at[1], 16);
        end
        check("wrap.rd_valid_count", rdv_seen, 20);

        // reset with count 3 and a pop in flight
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 9'h030 + 9'(i));
        cycle(0, 0, 1, 0, '0);
        drive(1, 0, 1, 0, '0);
        commit();
        drive(0, 0, 0, 0, '0);
        check("rst_mid.rd_valid", rd_valid, 0);
        check("rst_mid.busy", busy, 1);
        check("rst_mid.WrPtrClr", WrPtrClr, 1);
        check("rst_mid.RdPtrClr", RdPtrClr, 1);
        check("rst_mid.count", count, 0);
        commit();
        drive(0, 0, 0, 0, '0);
        check("rst_mid.run", busy, 0);
        commit();

        // randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            r = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 39) == 0);
            if (n < 400) begin
                p = ($urandom_range(0, 99) < 60);
                q = ($urandom_range(0, 99) < 40);
            end else begin
                p = ($urandom_range(0, 99) < 40);
                q = ($urandom_range(0, 99) < 60);
            end
            cycle(r, p, q, f, 9'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fifo8x9_ctrl
